fpu_sequencer: RTL and testbench
================================

Name: fpu_sequencer

Overview:
- Issues one floating-point operation at a time to the shared float DSP datapath and waits that operation's fixed latency.
- Captures the matching result output and returns it to the execute stage over a valid/ready handshake.
- Guarantees the operand-stability and single-cycle start-pulse rules the datapath's pipelined and iterative units depend on.
- Sits between the execute stage and the float DSP; the execute stage stalls on req_ready low.

Parameters:
- LAT_CMP, 1, cycles from START to valid eq/lt/lte result
- LAT_ADD, 2, cycles from START to valid add/sub result
- LAT_MUL, 4, cycles from START to valid mul result
- LAT_F2I, 2, cycles from START to valid float-to-int result
- LAT_I2F, 33, cycles from START to valid int-to-float result (iterative)
- LAT_DIV, 24, cycles from START to valid div result (iterative)
- LAT_SQRT, 24, cycles from START to valid sqrt result
- CNT_W, 6, width of latency counter; must hold max LAT

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  alu_op_t  requested float operation
- req_left  in  32  left operand
- req_right  in  32  right operand
- req_rd  in  5  destination tag, returned unchanged
- flush  in  1  abort the in-flight request without a response
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  32  result
- resp_rd  out  5  tag of result
- resp_illegal  out  1  req_op was not a float op
- dsp_alu_op  out  alu_op_t  op to datapath
- dsp_left, dsp_right  out  32  operands to datapath
- dsp_int_float, dsp_float_int, dsp_add, dsp_sub, dsp_mul, dsp_div, dsp_sqrt  in  32  datapath results
- dsp_eq, dsp_lt, dsp_lte  in  1  datapath compare results

Behaviour:
- Reset values: state IDLE; req_ready 1; resp_valid 0; resp_data 0; resp_rd 0; resp_illegal 0; dsp_alu_op ALU_NOP; dsp_left and dsp_right 0; counter 0.
- States: IDLE, SETUP, START, WAIT, RESP, DRAIN.
- req_ready = (state == IDLE). dsp_alu_op = latched op in START only, ALU_NOP in every other state.
- IDLE:
  - On req_valid && req_ready at cycle T, latch op, left, right and rd.
  - Float ops are ALU_F_ADD, ALU_F_SUB, ALU_F_MUL, ALU_F_DIV, ALU_F_SQRT, ALU_F_EQ, ALU_F_LT, ALU_F_LTE, ALU_F_INT_FLOAT and ALU_F_FLOAT_INT. Any of these goes to SETUP.
  - Any other op goes directly to RESP with resp_data 0 and resp_illegal 1.
- SETUP:
  - Lasts 2 cycles (T+1, T+2) so the datapath's two-stage delayed operand copies are valid.
  - dsp_left and dsp_right show the latched operands from T+1 and stay stable until state leaves WAIT.
- START:
  - Occupies 1 cycle (S = T+3).
  - Counter loads LAT(op)-1. Next state is WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where the counter is 0 (end of cycle S+LAT), resp_data loads the selected result and the state moves to RESP.
  - Compare results are zero-extended to 32 bits. ALU_F_SUB selects dsp_sub.
- RESP:
  - resp_valid is 1 from cycle T+4+LAT.
  - resp_data, resp_rd and resp_illegal stay stable until resp_valid && resp_ready. On that handshake resp_valid clears and the state returns to IDLE.
  - A new request can be accepted only in the cycle after the handshake; there is no bypass.
- flush:
  - In SETUP or RESP: go to IDLE next cycle, resp_valid clears, and no response is produced.
  - In START or WAIT: go to DRAIN, keeping the counter running and holding dsp_alu_op at ALU_NOP. DRAIN returns to IDLE when the counter reaches 0 and nothing is captured. This keeps a new start from colliding with a still-running iterative unit.
  - In IDLE: ignored. A req_valid in the same cycle as flush is still accepted.
- rst mid-operation: immediate return to the reset values; the datapath is reset by the same rst.
- Only one operation is in flight at a time; there is no queue.

Test Plan:
- ADD 0x3F800000 + 0x40000000, accepted cycle 10 -> resp_valid rises cycle 16, resp_data 0x40400000, resp_rd echoed; dsp_alu_op = ALU_F_ADD only in cycle 13.
- DIV 0x40C00000 / 0x40000000 with resp_ready held 0 for 5 cycles -> resp_valid first high at T+28; resp_data 0x40400000 held stable until resp_ready; req_ready low throughout.
- LT 0xBF800000 < 0x3F800000 -> resp_data 0x00000001; LTE of -0.0 vs +0.0 -> resp_data 0x00000001.
- INT_FLOAT of 0xFFFFFFFB (-5), then a new request in the cycle after the handshake -> first resp 0xC0A00000; second request's START lands no earlier than 3 cycles after its acceptance.
- flush asserted in WAIT of a DIV at cycle S+5 -> no resp_valid; req_ready stays 0 until cycle S+LAT_DIV+1; a following MUL 2.0*3.0 returns 0x40C00000.
- Non-float op (ALU_ADD) -> resp_valid cycle T+1, resp_illegal 1, resp_data 0. Separately, rst during WAIT -> all outputs at reset values next cycle and req_ready 1.

Source files
------------

// File: rtl/fpu_sequencer.sv
// Float DSP sequencer: issues one float op at a time, waits its fixed latency and returns the
// result over valid/ready; operands stay stable from SETUP until the result is taken or drained.
package fpu_sequencer_pkg;
  typedef enum logic [4:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_F_ADD, ALU_F_SUB, ALU_F_MUL, ALU_F_DIV, ALU_F_SQRT,
    ALU_F_EQ, ALU_F_LT, ALU_F_LTE, ALU_F_INT_FLOAT, ALU_F_FLOAT_INT
  } alu_op_t;
endpackage

module fpu_sequencer
  import fpu_sequencer_pkg::*;
#(
  parameter int LAT_CMP  = 1,
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 4,
  parameter int LAT_F2I  = 2,
  parameter int LAT_I2F  = 33,
  parameter int LAT_DIV  = 24,
  parameter int LAT_SQRT = 24,
  parameter int CNT_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  alu_op_t     req_op,
  input  logic [31:0] req_left,
  input  logic [31:0] req_right,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_illegal,
  output alu_op_t     dsp_alu_op,
  output logic [31:0] dsp_left,
  output logic [31:0] dsp_right,
  input  logic [31:0] dsp_int_float,
  input  logic [31:0] dsp_float_int,
  input  logic [31:0] dsp_add,
  input  logic [31:0] dsp_sub,
  input  logic [31:0] dsp_mul,
  input  logic [31:0] dsp_div,
  input  logic [31:0] dsp_sqrt,
  input  logic        dsp_eq,
  input  logic        dsp_lt,
  input  logic        dsp_lte
);

  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, RESP, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  alu_op_t           op_q, op_d;
  logic [31:0]       left_q, left_d, right_q, right_d, data_q, data_d, result;
  logic [4:0]        rd_q, rd_d;
  logic              ill_q, ill_d;

  function automatic logic is_float(alu_op_t op);
    return op inside {ALU_F_ADD, ALU_F_SUB, ALU_F_MUL, ALU_F_DIV, ALU_F_SQRT,
                      ALU_F_EQ, ALU_F_LT, ALU_F_LTE, ALU_F_INT_FLOAT, ALU_F_FLOAT_INT};
  endfunction

  // Counter is loaded with LAT-1 in START so it reaches 0 in the result cycle S+LAT.
  function automatic logic [CNT_W-1:0] lat_m1(alu_op_t op);
    case (op)
      ALU_F_EQ, ALU_F_LT, ALU_F_LTE: return CNT_W'(LAT_CMP - 1);
      ALU_F_ADD, ALU_F_SUB:          return CNT_W'(LAT_ADD - 1);
      ALU_F_MUL:                     return CNT_W'(LAT_MUL - 1);
      ALU_F_FLOAT_INT:               return CNT_W'(LAT_F2I - 1);
      ALU_F_INT_FLOAT:               return CNT_W'(LAT_I2F - 1);
      ALU_F_DIV:                     return CNT_W'(LAT_DIV - 1);
      ALU_F_SQRT:                    return CNT_W'(LAT_SQRT - 1);
      default:                       return '0;
    endcase
  endfunction

  always_comb begin
    result = '0;
    case (op_q)
      ALU_F_ADD:       result = dsp_add;
      ALU_F_SUB:       result = dsp_sub;
      ALU_F_MUL:       result = dsp_mul;
      ALU_F_DIV:       result = dsp_div;
      ALU_F_SQRT:      result = dsp_sqrt;
      ALU_F_EQ:        result = {31'b0, dsp_eq};
      ALU_F_LT:        result = {31'b0, dsp_lt};
      ALU_F_LTE:       result = {31'b0, dsp_lte};
      ALU_F_INT_FLOAT: result = dsp_int_float;
      ALU_F_FLOAT_INT: result = dsp_float_int;
      default:         result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    left_d  = left_q;
    right_d = right_q;
    rd_d    = rd_q;
    data_d  = data_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          left_d  = req_left;
          right_d = req_right;
          rd_d    = req_rd;
          if (is_float(req_op)) begin
            state_d = SETUP;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = RESP;
            data_d  = '0;
            ill_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        if (flush)               state_d = IDLE;
        else if (cnt_q == '0)    state_d = START;
        else                     cnt_d   = cnt_q - CNT_W'(1);
      end
      START: begin
        cnt_d   = lat_m1(op_q);
        state_d = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            state_d = RESP;
            data_d  = result;
            ill_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (flush) state_d = DRAIN;
        end
      end
      RESP: begin
        if (flush || resp_ready) state_d = IDLE;
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= ALU_NOP;
      left_q  <= '0;
      right_q <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      left_q  <= left_d;
      right_q <= right_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      ill_q   <= ill_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_data    = data_q;
  assign resp_rd      = rd_q;
  assign resp_illegal = ill_q;
  assign dsp_alu_op   = (state_q == START) ? op_q : ALU_NOP;
  assign dsp_left     = left_q;
  assign dsp_right    = right_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer; a small datapath model drives each result bus with the
// expected value only in the exact cycle START+LAT, and with inverted data at all other times.
module tb_fpu_sequencer;
  import fpu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req_valid, flush, resp_ready;
  alu_op_t     req_op;
  logic [31:0] req_left, req_right;
  logic [4:0]  req_rd;
  logic        req_ready, resp_valid, resp_illegal;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  alu_op_t     dsp_alu_op;
  logic [31:0] dsp_left, dsp_right;
  logic [31:0] dsp_int_float, dsp_float_int, dsp_add, dsp_sub, dsp_mul, dsp_div, dsp_sqrt;
  logic        dsp_eq, dsp_lt, dsp_lte;

  int          cyc = 0, n_starts = 0, s_cyc = 0;
  alu_op_t     m_op = ALU_NOP;
  logic [31:0] m_res = '0, m_left = '0, m_right = '0;
  logic        win;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  fpu_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_left(req_left), .req_right(req_right), .req_rd(req_rd), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_illegal(resp_illegal), .dsp_alu_op(dsp_alu_op), .dsp_left(dsp_left),
    .dsp_right(dsp_right), .dsp_int_float(dsp_int_float), .dsp_float_int(dsp_float_int),
    .dsp_add(dsp_add), .dsp_sub(dsp_sub), .dsp_mul(dsp_mul), .dsp_div(dsp_div),
    .dsp_sqrt(dsp_sqrt), .dsp_eq(dsp_eq), .dsp_lt(dsp_lt), .dsp_lte(dsp_lte)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lat(alu_op_t op);
    case (op)
      ALU_F_EQ, ALU_F_LT, ALU_F_LTE:        return 1;
      ALU_F_ADD, ALU_F_SUB, ALU_F_FLOAT_INT: return 2;
      ALU_F_MUL:                            return 4;
      ALU_F_INT_FLOAT:                      return 33;
      ALU_F_DIV, ALU_F_SQRT:                return 24;
      default:                              return 0;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Start pulses are observed mid-cycle; operands must already be the accepted ones.
  always @(negedge clk) begin
    if (dsp_alu_op != ALU_NOP) begin
      n_starts = n_starts + 1;
      s_cyc    = cyc;
      m_op     = dsp_alu_op;
      check("start_left", dsp_left, m_left);
      check("start_right", dsp_right, m_right);
    end
  end

  always_comb begin
    win           = (n_starts > 0) && (cyc == s_cyc + lat(m_op));
    dsp_add       = ~m_res;
    dsp_sub       = ~m_res;
    dsp_mul       = ~m_res;
    dsp_div       = ~m_res;
    dsp_sqrt      = ~m_res;
    dsp_int_float = ~m_res;
    dsp_float_int = ~m_res;
    dsp_eq        = ~m_res[0];
    dsp_lt        = ~m_res[0];
    dsp_lte       = ~m_res[0];
    if (win) begin
      case (m_op)
        ALU_F_ADD:       dsp_add       = m_res;
        ALU_F_SUB:       dsp_sub       = m_res;
        ALU_F_MUL:       dsp_mul       = m_res;
        ALU_F_DIV:       dsp_div       = m_res;
        ALU_F_SQRT:      dsp_sqrt      = m_res;
        ALU_F_INT_FLOAT: dsp_int_float = m_res;
        ALU_F_FLOAT_INT: dsp_float_int = m_res;
        ALU_F_EQ:        dsp_eq        = m_res[0];
        ALU_F_LT:        dsp_lt        = m_res[0];
        ALU_F_LTE:       dsp_lte       = m_res[0];
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input alu_op_t op, input logic [31:0] l, input logic [31:0] r,
                        input logic [4:0] rd, input logic [31:0] res, input logic fl,
                        output int t);
    int n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    check("ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_left = l; req_right = r; req_rd = rd; flush = fl;
    m_left = l; m_right = r; m_res = res;
    t = cyc;
    tick();
    req_valid = 1'b0; req_op = ALU_NOP; flush = 1'b0;
  endtask

  task automatic run_op(input string tag, input alu_op_t op, input logic [31:0] l,
                        input logic [31:0] r, input logic [4:0] rd, input logic [31:0] res,
                        input int dly, input logic ill, input int hold, input logic fl);
    int t, n0, n, busy;
    logic stable;
    n0 = n_starts;
    accept(op, l, r, rd, res, fl, t);
    busy = 0; n = 0;
    while (!resp_valid && n < 60) begin
      if (req_ready) busy++;
      tick(); n++;
    end
    check({tag, "_resp_cycle"}, 32'(cyc - t), 32'(dly));
    check({tag, "_data"}, resp_data, res);
    check({tag, "_rd"}, 32'(resp_rd), 32'(rd));
    check({tag, "_illegal"}, 32'(resp_illegal), 32'(ill));
    check({tag, "_ready_low"}, 32'(busy), 32'd0);
    check({tag, "_starts"}, 32'(n_starts - n0), ill ? 32'd0 : 32'd1);
    if (!ill) check({tag, "_start_cycle"}, 32'(s_cyc - t), 32'd3);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      stable &= resp_valid && (resp_data == res) && !req_ready;
    end
    if (hold > 0) check({tag, "_hold_stable"}, 32'(stable), 32'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_valid_cleared"}, 32'(resp_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int t, s, n, n0;
    logic seen;
    rst = 1'b1; req_valid = 1'b0; req_op = ALU_NOP; req_left = '0; req_right = '0;
    req_rd = '0; flush = 1'b0; resp_ready = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_rd", 32'(resp_rd), 32'd0);
    check("rst_illegal", 32'(resp_illegal), 32'd0);
    check("rst_dsp_op", 32'(dsp_alu_op), 32'(ALU_NOP));
    check("rst_dsp_left", dsp_left, 32'd0);
    check("rst_dsp_right", dsp_right, 32'd0);
    rst = 1'b0;
    tick();

    run_op("add",  ALU_F_ADD,  32'h3F800000, 32'h40000000, 5'd5,  32'h40400000, 6,  1'b0, 0, 1'b0);
    run_op("div",  ALU_F_DIV,  32'h40C00000, 32'h40000000, 5'd9,  32'h40400000, 28, 1'b0, 5, 1'b0);
    run_op("lt",   ALU_F_LT,   32'hBF800000, 32'h3F800000, 5'd1,  32'h00000001, 5,  1'b0, 0, 1'b0);
    run_op("lte",  ALU_F_LTE,  32'h80000000, 32'h00000000, 5'd2,  32'h00000001, 5,  1'b0, 0, 1'b0);
    run_op("eq0",  ALU_F_EQ,   32'h3F800000, 32'h40000000, 5'd3,  32'h00000000, 5,  1'b0, 0, 1'b0);
    run_op("sub",  ALU_F_SUB,  32'h40400000, 32'h3F800000, 5'd4,  32'h40000000, 6,  1'b0, 0, 1'b0);
    run_op("sqrt", ALU_F_SQRT, 32'h41100000, 32'h00000000, 5'd6,  32'h40400000, 28, 1'b0, 2, 1'b0);
    run_op("f2i",  ALU_F_FLOAT_INT, 32'h40E00000, 32'h0, 5'd7,  32'h00000007, 6,  1'b0, 0, 1'b0);
    run_op("i2f",  ALU_F_INT_FLOAT, 32'hFFFFFFFB, 32'h0, 5'd8,  32'hC0A00000, 37, 1'b0, 0, 1'b0);
    run_op("eq_b2b", ALU_F_EQ, 32'h3F800000, 32'h3F800000, 5'd10, 32'h00000001, 5, 1'b0, 0, 1'b0);

    // Flush during WAIT of a DIV: DRAIN until the divider would have finished.
    accept(ALU_F_DIV, 32'h40C00000, 32'h40000000, 5'd11, 32'h40400000, 1'b0, t);
    n = 0;
    while (dsp_alu_op != ALU_F_DIV && n < 10) begin tick(); n++; end
    s = cyc;
    check("fdiv_start_cycle", 32'(s - t), 32'd3);
    while (cyc < s + 5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 1'b0; n = 0;
    while (!req_ready && n < 60) begin seen |= resp_valid; tick(); n++; end
    seen |= resp_valid;
    check("fdiv_idle_cycle", 32'(cyc - s), 32'd25);
    check("fdiv_no_resp", 32'(seen), 32'd0);
    run_op("mul_after_flush", ALU_F_MUL, 32'h40000000, 32'h40400000, 5'd12, 32'h40C00000, 8, 1'b0, 0, 1'b0);

    // Flush during SETUP: back to IDLE next cycle, never starts the datapath.
    n0 = n_starts;
    accept(ALU_F_ADD, 32'h3F800000, 32'h3F800000, 5'd13, 32'h40000000, 1'b0, t);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fsetup_ready", 32'(req_ready), 32'd1);
    repeat (5) tick();
    check("fsetup_no_start", 32'(n_starts - n0), 32'd0);

    // Flush during RESP drops the response.
    accept(ALU_F_EQ, 32'h3F800000, 32'h3F800000, 5'd14, 32'h00000001, 1'b0, t);
    n = 0;
    while (!resp_valid && n < 20) begin tick(); n++; end
    check("fresp_valid_seen", 32'(resp_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fresp_valid_clr", 32'(resp_valid), 32'd0);
    check("fresp_ready", 32'(req_ready), 32'd1);

    // Flush in IDLE is ignored; the simultaneous request proceeds normally.
    run_op("idle_flush_add", ALU_F_ADD, 32'h3F800000, 32'h40000000, 5'd15, 32'h40400000, 6, 1'b0, 0, 1'b1);
    run_op("illegal", ALU_ADD, 32'h00000001, 32'h00000002, 5'd16, 32'h00000000, 1, 1'b1, 1, 1'b0);
    run_op("mul", ALU_F_MUL, 32'h40000000, 32'h40400000, 5'd17, 32'h40C00000, 8, 1'b0, 0, 1'b0);

    // Reset in the middle of a DIV wait.
    accept(ALU_F_DIV, 32'h40C00000, 32'h40000000, 5'd18, 32'h40400000, 1'b0, t);
    repeat (8) tick();
    check("mid_busy", 32'(req_ready), 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_data", resp_data, 32'd0);
    check("mid_rst_rd", 32'(resp_rd), 32'd0);
    check("mid_rst_op", 32'(dsp_alu_op), 32'(ALU_NOP));
    check("mid_rst_left", dsp_left, 32'd0);
    check("mid_rst_right", dsp_right, 32'd0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
